sbio_rx_deframer: RTL and testbench

- Receive-side framing stage for the 2-pin serial link between the FPGA and the Pico PIO RAM emulator.
- Sits directly downstream of the registered rx input pins. Detects the active-low start cycle and shifts in a fixed-length message (header cycles, then data cycles).
- Timestamps each message and buffers it in a small FIFO. Presents messages to the consumer (tester or RAM client) with a valid/ready handshake.
- Replaces ad-hoc per-design rx shift registers with one reusable, flow-controlled stage.

---
 rtl/sbio_rx_deframer.sv | 223 ++++++++++++++++++++++
 tb/tb_sbio_rx_deframer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sbio_rx_deframer.sv
// Receive-side deframer for the 2-pin PIO RAM link: detects the active-low start
// cycle, shifts in header and data, timestamps the message and queues it for the consumer.
module sbio_rx_deframer #(
  parameter int IO_BITS          = 2,
  parameter int RX_HEADER_CYCLES = 2,
  parameter int RX_DATA_CYCLES   = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int TS_BITS          = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [IO_BITS-1:0]                   rx_pins,
  input  logic                                 enable,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IO_BITS*RX_HEADER_CYCLES-1:0]  out_header,
  output logic [IO_BITS*RX_DATA_CYCLES-1:0]    out_data,
  output logic [TS_BITS-1:0]                   out_timestamp,
  output logic                                 overflow,
  input  logic                                 clear_overflow,
  output logic [15:0]                          msg_count,
  output logic                                 busy
);

  localparam int HDR_W   = IO_BITS * RX_HEADER_CYCLES;
  localparam int DAT_W   = IO_BITS * RX_DATA_CYCLES;
  localparam int ENTRY_W = TS_BITS + HDR_W + DAT_W;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_CYC = (RX_HEADER_CYCLES > RX_DATA_CYCLES) ? RX_HEADER_CYCLES : RX_DATA_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(RX_HEADER_CYCLES - 1);
  localparam logic [CNT_W-1:0] DAT_LAST  = CNT_W'(RX_DATA_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT0_FIFO = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   CNT1_FIFO = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_start;
  logic                w_last_data;

  logic [TS_BITS-1:0]  r_ts;
  logic [TS_BITS-1:0]  r_start_ts;
  logic [HDR_W-1:0]    r_hdr;
  logic [DAT_W-1:0]    r_dat;
  logic                r_push;
  logic                r_busy;

  logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic [PTR_W:0]      w_count_next;
  logic                r_out_valid;
  logic                r_overflow;
  logic [15:0]         r_msg_count;

  logic                w_pop;
  logic                w_full;
  logic                w_push_ok;
  logic                w_drop;

  // Free-running timestamp counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= TS_BITS'(0);
    end else begin
      r_ts <= r_ts + TS_BITS'(1);
    end
  end

  // FSM state and cycle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != ST_IDLE);
    end
  end

  // FSM next-state: enable gates only the start detect, an open message always completes
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_last_data  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && (rx_pins[0] == 1'b0)) begin
          w_state_next = ST_HEADER;
          w_cnt_next   = CNT_ZERO;
          w_start      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = CNT_ZERO;
        end
      end
      ST_HEADER: begin
        if (r_cnt == HDR_LAST) begin
          w_state_next = ST_DATA;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_HEADER;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (r_cnt == DAT_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = CNT_ZERO;
          w_last_data  = 1'b1;
        end else begin
          w_state_next = ST_DATA;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Shift registers (new pins enter at the MSB end) and start-cycle timestamp latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hdr      <= HDR_W'(0);
      r_dat      <= DAT_W'(0);
      r_start_ts <= TS_BITS'(0);
      r_push     <= 1'b0;
    end else begin
      if (r_state == ST_HEADER) begin
        r_hdr <= {rx_pins, r_hdr[HDR_W-1:IO_BITS]};
      end
      if (r_state == ST_DATA) begin
        r_dat <= {rx_pins, r_dat[DAT_W-1:IO_BITS]};
      end
      if (w_start) begin
        r_start_ts <= r_ts;
      end
      r_push <= w_last_data;
    end
  end

  // FIFO handshake: a pop in the push cycle frees room for the incoming message
  always_comb begin
    w_pop     = r_out_valid && out_ready;
    w_full    = (r_count == FIFO_FULL);
    w_push_ok = r_push && (!w_full || w_pop);
    w_drop    = r_push && w_full && !w_pop;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + CNT1_FIFO;
      2'b01:   w_count_next = r_count - CNT1_FIFO;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage; entries need no reset because out_valid masks them
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {r_start_ts, r_hdr, r_dat};
    end
  end

  // FIFO pointers, occupancy and registered valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= PTR_W'(0);
      r_rd_ptr    <= PTR_W'(0);
      r_count     <= CNT0_FIFO;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != CNT0_FIFO);
    end
  end

  // Sticky overflow (clear wins) and accepted-message counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_msg_count <= 16'd0;
    end else begin
      if (clear_overflow) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push_ok) begin
        r_msg_count <= r_msg_count + 16'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign {out_timestamp, out_header, out_data} = r_mem[r_rd_ptr];
  assign overflow  = r_overflow;
  assign msg_count = r_msg_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sbio_rx_deframer.sv
// Directed self-checking bench for sbio_rx_deframer (IO_BITS=2, H=2, D=8, depth 4).
module tb_sbio_rx_deframer;

  logic        clk;
  logic        reset;
  logic [1:0]  rx_pins;
  logic        enable;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_header;
  logic [15:0] out_data;
  logic [15:0] out_timestamp;
  logic        overflow;
  logic        clear_overflow;
  logic [15:0] msg_count;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] tb_ts;
  logic [35:0] q[$];
  logic [15:0] t1, t2, t3, tx;

  sbio_rx_deframer dut (
    .clk            (clk),
    .reset          (reset),
    .rx_pins        (rx_pins),
    .enable         (enable),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_header     (out_header),
    .out_data       (out_data),
    .out_timestamp  (out_timestamp),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .msg_count      (msg_count),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: cleared by reset, +1 every cycle
  always @(posedge clk) begin
    if (reset) tb_ts <= 16'd0;
    else       tb_ts <= tb_ts + 16'd1;
  end

  // Record every handshake as {ts, header, data}
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      q.push_back({out_timestamp, out_header, out_data});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  // Start cycle, 2 header cycles, 8 data cycles; returns in the cycle after the last data cycle
  task automatic send_msg(input logic [3:0] h, input logic [15:0] d, input int en_drop,
                          output logic [15:0] ts);
    ts = tb_ts;
    for (int c = 0; c < 11; c++) begin
      if (c == 0)     rx_pins = 2'b00;
      else if (c < 3) rx_pins = h[2*(c-1) +: 2];
      else            rx_pins = d[2*(c-3) +: 2];
      if (c == en_drop) enable = 1'b0;
      tick();
    end
    rx_pins = 2'b11;
    enable  = 1'b1;
  endtask

  task automatic check_q(input string tag, input int idx, input logic [15:0] exp_data);
    if (idx < q.size()) check_val(tag, q[idx][15:0], exp_data);
    else                check_val({tag, "_missing"}, q.size(), idx + 1);
  endtask

  initial begin
    reset = 1'b1; rx_pins = 2'b11; enable = 1'b1; out_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_count", msg_count, 16'd0);
    check_val("rst_busy", busy, 1'b0);

    // Single message, latency 12 cycles, one-cycle valid
    out_ready = 1'b1;
    send_msg(4'h9, 16'h1B1B, -1, t1);
    check_val("single_valid_c11", out_valid, 1'b0);
    check_val("single_busy_c11", busy, 1'b0);
    tick();
    check_val("single_valid_c12", out_valid, 1'b1);
    check_val("single_hdr", out_header, 4'h9);
    check_val("single_data", out_data, 16'h1B1B);
    check_val("single_ts", out_timestamp, t1);
    check_val("single_count", msg_count, 16'd1);
    tick();
    check_val("single_valid_c13", out_valid, 1'b0);

    // Back-to-back messages
    q.delete();
    send_msg(4'h5, 16'h0001, -1, t1);
    send_msg(4'h5, 16'h0002, -1, t2);
    send_msg(4'h5, 16'h0003, -1, t3);
    tick(); tick(); tick();
    check_val("b2b_pops", q.size(), 3);
    check_q("b2b_d0", 0, 16'h0001);
    check_q("b2b_d1", 1, 16'h0002);
    check_q("b2b_d2", 2, 16'h0003);
    if (q.size() == 3) begin
      check_val("b2b_ts0", q[0][35:20], t1);
      check_val("b2b_dts1", q[1][35:20] - q[0][35:20], 16'd11);
      check_val("b2b_dts2", q[2][35:20] - q[1][35:20], 16'd11);
    end
    check_val("b2b_count", msg_count, 16'd4);

    // enable low: start cycle ignored
    do_reset();
    out_ready = 1'b0;
    enable = 1'b0;
    rx_pins = 2'b00;
    tick();
    check_val("en0_busy_a", busy, 1'b0);
    enable = 1'b0;
    send_msg(4'h3, 16'h1234, 0, tx);
    tick(); tick();
    check_val("en0_busy_b", busy, 1'b0);
    check_val("en0_valid", out_valid, 1'b0);
    check_val("en0_count", msg_count, 16'd0);

    // enable dropped in 3rd data cycle: message completes
    send_msg(4'h6, 16'hC35A, 5, tx);
    tick();
    check_val("endrop_valid", out_valid, 1'b1);
    check_val("endrop_hdr", out_header, 4'h6);
    check_val("endrop_data", out_data, 16'hC35A);
    check_val("endrop_ts", out_timestamp, tx);
    check_val("endrop_count", msg_count, 16'd1);

    // Reset in the 2nd header cycle
    rx_pins = 2'b00; tick();
    check_val("rstmid_busy_pre", busy, 1'b1);
    rx_pins = 2'b01; tick();
    rx_pins = 2'b10; reset = 1'b1; tick();
    reset = 1'b0; rx_pins = 2'b11;
    check_val("rstmid_busy", busy, 1'b0);
    check_val("rstmid_valid", out_valid, 1'b0);
    check_val("rstmid_count", msg_count, 16'd0);
    send_msg(4'hC, 16'hA5F0, -1, tx);
    tick();
    check_val("rstmid_after_valid", out_valid, 1'b1);
    check_val("rstmid_after_hdr", out_header, 4'hC);
    check_val("rstmid_after_data", out_data, 16'hA5F0);
    check_val("rstmid_after_ts", out_timestamp, tx);

    // Backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    send_msg(4'hA, 16'h0011, -1, t1);
    for (int i = 2; i <= 5; i++) send_msg(4'hA, 16'(16'h0010 + i), -1, tx);
    tick();
    check_val("ovf_flag", overflow, 1'b1);
    check_val("ovf_count", msg_count, 16'd4);
    check_val("ovf_valid", out_valid, 1'b1);
    check_val("ovf_head", out_data, 16'h0011);
    check_val("ovf_head_ts", out_timestamp, t1);
    tick(); tick();
    check_val("ovf_head_stable", out_data, 16'h0011);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    check_val("ovf_drained", q.size(), 4);
    for (int i = 0; i < 4; i++) check_q($sformatf("ovf_d%0d", i), i, 16'(16'h0011 + i));
    check_val("ovf_empty", out_valid, 1'b0);
    check_val("ovf_sticky", overflow, 1'b1);
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    check_val("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a pop exactly in the push cycle of message 5
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_msg(4'h1, 16'(16'h0020 + i), -1, tx);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_val("fullpop_overflow", overflow, 1'b0);
    check_val("fullpop_count", msg_count, 16'd5);
    check_val("fullpop_head", out_data, 16'h0022);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    check_val("fullpop_drained", q.size(), 5);
    for (int i = 0; i < 5; i++) check_q($sformatf("fullpop_d%0d", i), i, 16'(16'h0021 + i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
